// File: rtl/layer_train_driver_if.sv
// Shared value type and the sample/layer bus between the
// training sequencer and its neighbours.
package layer_train_pkg;
  localparam int ZW = 8;
  typedef logic [ZW-1:0] zero2one_t;
endpackage

interface layer_train_driver_if #(
  parameter int N = 16,
  parameter int M = 31
) ();
  import layer_train_pkg::*;
  localparam int LW = $clog2(M);

  logic                s_valid;
  logic                s_ready;
  zero2one_t [N-1:0]   s_in;
  logic [LW-1:0]       s_label;
  logic                learn_en;
  zero2one_t [N-1:0]   layer_in;
  logic                layer_valid;
  logic                layer_learn;
  zero2one_t [M-1:0]   layer_out;
  zero2one_t [M-1:0]   expected_out;
  logic                done;
  logic [LW-1:0]       predicted;
  logic                correct;
  logic                label_err;
  logic [31:0]         sample_count;
  logic [31:0]         correct_count;

  modport slave (
    input  s_valid, s_in, s_label, learn_en,
    input  layer_out,
    output s_ready, layer_in, layer_valid,
    output layer_learn, expected_out, done,
    output predicted, correct, label_err,
    output sample_count, correct_count
  );

  modport master (
    output s_valid, s_in, s_label, learn_en,
    output layer_out,
    input  s_ready, layer_in, layer_valid,
    input  layer_learn, expected_out, done,
    input  predicted, correct, label_err,
    input  sample_count, correct_count
  );
endinterface

// File: rtl/layer_train_driver.sv
// Sequencer feeding one sample at a time to a neuron layer:
// forward pass, argmax, optional learn pulse, result report.
module layer_train_driver
  import layer_train_pkg::*;
#(
  parameter int N      = 16,
  parameter int M      = 31,
  parameter int SETTLE = 4
) (
  input  logic clock,
  input  logic reset,
  layer_train_driver_if.slave bus
);
  localparam int LW = $clog2(M);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE, FWD, EVAL, LEARN, REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  zero2one_t [N-1:0] in_q, in_d;
  logic [LW-1:0]     label_q, label_d;
  logic              le_q, le_d;
  zero2one_t [M-1:0] out_q, out_d;
  logic [LW-1:0]     arg_q, arg_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              learn_q, learn_d;
  logic              done_q, done_d;
  zero2one_t [M-1:0] exp_q, exp_d;
  logic [LW-1:0]     pred_q, pred_d;
  logic              corr_q, corr_d;
  logic              lerr_q, lerr_d;
  logic [31:0]       samp_q, samp_d;
  logic [31:0]       ccnt_q, ccnt_d;

  logic              label_ok;
  logic [LW-1:0]     best_idx;
  zero2one_t         best;

  assign label_ok = (int'(label_q) < M);

  // strict compare keeps the lowest index on ties
  always_comb begin
    best     = out_q[0];
    best_idx = '0;
    for (int i = 1; i < M; i++) begin
      if (out_q[i] > best) begin
        best     = out_q[i];
        best_idx = LW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    label_d = label_q;
    le_d    = le_q;
    out_d   = out_q;
    arg_d   = arg_q;
    valid_d = 1'b0;
    learn_d = 1'b0;
    done_d  = 1'b0;
    exp_d   = exp_q;
    pred_d  = pred_q;
    corr_d  = corr_q;
    lerr_d  = lerr_q;
    samp_d  = samp_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s_valid && ready_q) begin
          in_d    = bus.s_in;
          label_d = bus.s_label;
          le_d    = bus.learn_en;
          cnt_d   = CW'(SETTLE - 1);
          valid_d = 1'b1;
          state_d = FWD;
        end
      end
      FWD: begin
        if (cnt_q == '0) begin
          out_d   = bus.layer_out;
          state_d = EVAL;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          valid_d = 1'b1;
        end
      end
      EVAL: begin
        arg_d   = best_idx;
        valid_d = le_q && label_ok;
        learn_d = le_q && label_ok;
        for (int i = 0; i < M; i++) begin
          exp_d[i] = (label_ok && int'(label_q) == i)
                   ? '1 : '0;
        end
        state_d = LEARN;
      end
      LEARN: begin
        done_d  = 1'b1;
        pred_d  = arg_q;
        corr_d  = label_ok && (arg_q == label_q);
        lerr_d  = !label_ok;
        samp_d  = (&samp_q) ? samp_q : samp_q + 1;
        if (label_ok && (arg_q == label_q)) begin
          ccnt_d = (&ccnt_q) ? ccnt_q : ccnt_q + 1;
        end
        state_d = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      label_q <= '0;
      le_q    <= 1'b0;
      out_q   <= '0;
      arg_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      learn_q <= 1'b0;
      done_q  <= 1'b0;
      exp_q   <= '0;
      pred_q  <= '0;
      corr_q  <= 1'b0;
      lerr_q  <= 1'b0;
      samp_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      label_q <= label_d;
      le_q    <= le_d;
      out_q   <= out_d;
      arg_q   <= arg_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      learn_q <= learn_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
      pred_q  <= pred_d;
      corr_q  <= corr_d;
      lerr_q  <= lerr_d;
      samp_q  <= samp_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign bus.s_ready       = ready_q;
  assign bus.layer_in      = in_q;
  assign bus.layer_valid   = valid_q;
  assign bus.layer_learn   = learn_q;
  assign bus.expected_out  = exp_q;
  assign bus.done          = done_q;
  assign bus.predicted     = pred_q;
  assign bus.correct       = corr_q;
  assign bus.label_err     = lerr_q;
  assign bus.sample_count  = samp_q;
  assign bus.correct_count = ccnt_q;
endmodule

// File: tb/tb_layer_train_driver.sv
// Bench for layer_train_driver: timeline model of one sample
// in flight, checked every cycle, plus directed literals.
module tb_layer_train_driver;
  import layer_train_pkg::*;
  localparam int N      = 16;
  localparam int M      = 31;
  localparam int SETTLE = 4;
  localparam int LW     = $clog2(M);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_train_driver_if #(.N(N), .M(M)) bus ();

  layer_train_driver #(
    .N(N), .M(M), .SETTLE(SETTLE)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: offset of the sample in flight from its accept edge
  logic              busy = 1'b0;
  int                off  = 0;
  zero2one_t [N-1:0] m_in  = '0;
  logic [LW-1:0]     m_lab = '0;
  logic              m_le  = 1'b0;
  logic              m_ok  = 1'b0;
  logic [LW-1:0]     m_arg = '0;
  zero2one_t [M-1:0] m_exp = '0;
  logic [LW-1:0]     m_pred = '0;
  logic              m_corr = 1'b0;
  logic              m_lerr = 1'b0;
  logic [31:0]       m_sc = '0;
  logic [31:0]       m_cc = '0;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; off = 0; m_in = '0; m_exp = '0;
      m_pred = '0; m_corr = 1'b0; m_lerr = 1'b0;
      m_sc = '0; m_cc = '0;
    end else if (busy) begin
      off++;
      if (off == SETTLE) begin
        automatic zero2one_t mx = '0;
        for (int i = 0; i < M; i++)
          if (bus.layer_out[i] > mx) mx = bus.layer_out[i];
        for (int i = M - 1; i >= 0; i--)
          if (bus.layer_out[i] == mx) m_arg = LW'(i);
      end
      if (off == SETTLE + 1) begin
        m_exp = '0;
        if (m_ok) m_exp[m_lab] = '1;
      end
      if (off == SETTLE + 2) begin
        m_pred = m_arg;
        m_lerr = !m_ok;
        m_corr = m_ok && (m_arg == m_lab);
        if (m_sc != 32'hFFFF_FFFF) m_sc++;
        if (m_corr && m_cc != 32'hFFFF_FFFF) m_cc++;
      end
      if (off == SETTLE + 3) busy = 1'b0;
    end else if (bus.s_valid) begin
      busy  = 1'b1;
      off   = 0;
      m_in  = bus.s_in;
      m_lab = bus.s_label;
      m_le  = bus.learn_en;
      m_ok  = (int'(bus.s_label) < M);
    end
  end

  always @(posedge clk) begin
    #2;
    begin
      automatic logic lrn = busy && off == SETTLE + 1
                          && m_le && m_ok;
      automatic logic lv = busy && (off < SETTLE || lrn);
      chk("s_ready", bus.s_ready, !busy);
      chk("layer_valid", bus.layer_valid, lv);
      chk("layer_learn", bus.layer_learn, lrn);
      chk("done", bus.done, busy && off == SETTLE + 2);
      chk("layer_in", bus.layer_in, m_in);
      chk("expected_out", bus.expected_out, m_exp);
      chk("predicted", bus.predicted, m_pred);
      chk("correct", bus.correct, m_corr);
      chk("label_err", bus.label_err, m_lerr);
      chk("sample_count", bus.sample_count, m_sc);
      chk("correct_count", bus.correct_count, m_cc);
    end
  end

  task automatic fill_out(input int maxv);
    for (int i = 0; i < M; i++)
      bus.layer_out[i] = ZW'($urandom_range(0, maxv));
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 20 && !bus.s_ready; c++)
      @(negedge clk);
    if (!bus.s_ready) begin
      checks++; errors++;
      $display("FAIL wait_ready: got 0 want 1");
    end
  endtask

  task automatic run_sample(input logic [LW-1:0] lab,
                            input logic le,
                            output int lat,
                            output int nv,
                            output int nl);
    wait_ready();
    for (int i = 0; i < N; i++)
      bus.s_in[i] = ZW'($urandom);
    bus.s_label  = lab;
    bus.learn_en = le;
    bus.s_valid  = 1'b1;
    lat = 0; nv = 0; nl = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.s_valid = 1'b0;
      if (c == 2) bus.learn_en = !le;
      nv += int'(bus.layer_valid);
      nl += int'(bus.layer_learn);
      if (bus.done) lat = c;
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got none want done");
    end
  endtask

  int lat, nv, nl, ndone;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_in = '0;
    bus.s_label = '0;
    bus.learn_en = 1'b0;
    bus.layer_out = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_ready", bus.s_ready, 1);
    chk("idle_valid", bus.layer_valid, 0);
    chk("idle_count", bus.sample_count, 0);

    fill_out(150);
    bus.layer_out[5] = 8'd200;
    run_sample(5'd5, 1'b1, lat, nv, nl);
    chk("t2_latency", lat, 7);
    chk("t2_valid_cycles", nv, 5);
    chk("t2_learn_cycles", nl, 1);
    chk("t2_pred", bus.predicted, 5);
    chk("t2_correct", bus.correct, 1);
    chk("t2_exp5", bus.expected_out[5], 8'hFF);
    chk("t2_exp4", bus.expected_out[4], 0);
    chk("t2_counts", {bus.sample_count,
                      bus.correct_count}, {32'd1, 32'd1});

    fill_out(150);
    bus.layer_out[9]  = 8'd250;
    bus.layer_out[12] = 8'd250;
    run_sample(5'd5, 1'b0, lat, nv, nl);
    chk("t3_pred", bus.predicted, 9);
    chk("t3_correct", bus.correct, 0);
    chk("t3_learn_cycles", nl, 0);
    chk("t3_valid_cycles", nv, 4);
    chk("t3_counts", {bus.sample_count,
                      bus.correct_count}, {32'd2, 32'd1});

    fill_out(150);
    run_sample(5'd31, 1'b1, lat, nv, nl);
    chk("t4_label_err", bus.label_err, 1);
    chk("t4_correct", bus.correct, 0);
    chk("t4_learn_cycles", nl, 0);
    chk("t4_exp", bus.expected_out, 0);
    chk("t4_counts", {bus.sample_count,
                      bus.correct_count}, {32'd3, 32'd1});

    wait_ready();
    bus.s_label = 5'd7;
    bus.learn_en = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", bus.s_ready, 1);
    chk("t6_valid", bus.layer_valid, 0);
    chk("t6_layer_in", bus.layer_in, 0);
    chk("t6_count", bus.sample_count, 0);
    rst = 1'b0;
    fill_out(150);
    bus.layer_out[3] = 8'd255;
    run_sample(5'd3, 1'b1, lat, nv, nl);
    chk("t6_pred", bus.predicted, 3);
    chk("t6_counts", {bus.sample_count,
                      bus.correct_count}, {32'd1, 32'd1});

    wait_ready();
    @(negedge clk);
    ndone = 0;
    fill_out(7);
    bus.s_valid = 1'b1;
    repeat (240) begin
      @(negedge clk);
      if (bus.done) ndone++;
      for (int i = 0; i < N; i++)
        bus.s_in[i] = ZW'($urandom);
      bus.s_label = LW'($urandom_range(0, 31));
      bus.learn_en = 1'($urandom_range(0, 1));
      fill_out(7);
    end
    bus.s_valid = 1'b0;
    chk("t5_done_pulses", ndone, 30);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
